lsu_bus_ctrl: RTL and testbench
===============================

// Module: lsu_bus_ctrl
// PURPOSE
//  Parametrised load/store unit for the memory-access stage; successor to the combinational LS path.
//  Takes one load/store per handshake from EX and drives a req/gnt/rvalid data bus with byte strobes, so stores need no read-modify-write.
//  Returns sign/zero-extended load data and stalls the pipeline (hold_o) while a request is outstanding.
//  Reports misaligned, bus-error and timeout faults to the trap logic.
// PARAMETERS
//  XLEN        32    data/address width; 32 or 64
//  TIMEOUT_CYC 255   max cycles from mem_req_o to mem_rvalid_i before a timeout fault; 0 = no timeout
//  MISALIGN_EN 1     1: detect misaligned accesses and fault them; 0: force address LSBs to alignment
// PORTS
//  clk          in   1        clock; all state updates on the rising edge
//  rst          in   1        synchronous, active-high reset
//  req_valid_i  in   1        EX presents a memory op
//  req_ready_o  out  1        LSU accepts the op (state IDLE)
//  req_store_i  in   1        1 = store, 0 = load
//  req_funct3_i in   3        RV funct3: LB/LH/LW/LD/LBU/LHU/LWU and SB/SH/SW/SD
//  req_addr_i   in   XLEN     effective address from the ALU
//  req_wdata_i  in   XLEN     store data, rs2
//  flush_i      in   1        kill the op that has not yet been granted
//  rsp_valid_o  out  1        one-cycle pulse: op complete
//  rsp_rdata_o  out  XLEN     extended load data; 0 for stores
//  rsp_err_o    out  2        00 ok, 01 misaligned, 10 bus error, 11 timeout
//  hold_o       out  1        stall fetch/EX; high in REQ and WAIT
//  mem_req_o    out  1        bus request
//  mem_gnt_i    in   1        bus grant; address phase done
//  mem_we_o     out  1        write enable
//  mem_be_o     out  XLEN/8   byte strobes
//  mem_addr_o   out  XLEN     word-aligned address
//  mem_wdata_o  out  XLEN     store data lane-shifted into position
//  mem_rvalid_i in   1        response phase valid
//  mem_rdata_i  in   XLEN     read data (full word)
//  mem_err_i    in   1        bus error; sampled with mem_rvalid_i
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready_o=1; timeout counter 0; latched op cleared.
//  FSM states: IDLE, REQ, WAIT, RESP.
//   IDLE -> accept on req_valid_i & req_ready_o; latch addr/funct3/store/wdata.
//    Misaligned & MISALIGN_EN -> RESP with err=01; no bus traffic.
//    Otherwise -> REQ.
//   REQ  -> mem_req_o=1 and bus outputs held stable until mem_gnt_i.
//    flush_i before grant -> IDLE; no rsp_valid_o.
//    Grant -> WAIT; the bus transaction is no longer killable.
//   WAIT -> on mem_rvalid_i: register rdata/err -> RESP.
//    flush_i is ignored in WAIT; the response is consumed and dropped as if no flush had occurred only if flush_i arrived in REQ.
//   RESP -> rsp_valid_o=1 for exactly one cycle -> IDLE.
//  Latency: load/store with gnt in the REQ cycle and rvalid the cycle after -> rsp_valid_o 3 cycles after accept.
//  Alignment:
//   - byte: always aligned; half: addr[0]==0; word: addr[1:0]==0; dword (XLEN=64 only): addr[2:0]==0.
//   - funct3 LD/SD/LWU with XLEN=32 is treated as misaligned (err=01).
//  Strobes: mem_be_o = size mask << addr[log2(XLEN/8)-1:0]; mem_wdata_o = replicated low lanes of wdata.
//  Load extension: select lane by addr offset, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU).
//  Timeout counter:
//   - counts cycles in REQ+WAIT; saturates at TIMEOUT_CYC.
//   - on reaching TIMEOUT_CYC -> RESP with err=11.
//   - a late mem_rvalid_i after a timeout is ignored in IDLE.
//  Errors: mem_err_i=1 with rvalid -> err=10 and rsp_rdata_o=0; the store is assumed not performed.
//  rst mid-operation: immediate return to IDLE at the next edge; no rsp_valid_o; mem_req_o drops.
//  Simultaneous rvalid and timeout in the same cycle: rvalid wins (err=00/10).
// STRUCTURE
//  Shared package/defines: LSU_ERR_* codes, LSU state encodings, funct3 load/store constants (reuse INST_LB..INST_SW).
//  One sub-module, lsu_lane_align: combinational be/wdata shift and load extract/extend, parametrised by XLEN.
//  Top holds the FSM, latches and timeout counter.
// TESTING
//  1. SW addr 0x100, data 0xDEADBEEF; gnt immediate, rvalid +1 -> be=4'b1111, wdata=0xDEADBEEF, rsp_valid 3 cycles after accept, err=00.
//  2. SB addr 0x103, rs2=0x5A -> be=4'b1000, wdata[31:24]=0x5A; LB same addr with rdata=0x80xxxxxx -> rsp_rdata=0xFFFFFF80.
//  3. LH addr 0x101 -> err=01 and rsp_valid 1 cycle after accept; mem_req_o never asserted.
//  4. LW with gnt delayed 4 cycles, flush_i in cycle 2 -> FSM to IDLE, no rsp_valid, hold_o deasserts.
//  5. TIMEOUT_CYC=8, no rvalid -> err=11 after 8 cycles; a later rvalid is ignored; next op completes normally.
//  6. LHU addr 0x102, rdata=0x8001_0000 with mem_err_i=1 -> err=10, rdata=0; rst in WAIT -> IDLE, no pulse.

Source files
------------

// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared constants for the load/store bus controller: FSM encodings, fault codes,
// RISC-V load/store funct3 values and the latched-op payload.
package lsu_bus_ctrl_pkg;

  localparam logic [1:0] LSU_ST_IDLE = 2'd0;
  localparam logic [1:0] LSU_ST_REQ  = 2'd1;
  localparam logic [1:0] LSU_ST_WAIT = 2'd2;
  localparam logic [1:0] LSU_ST_RESP = 2'd3;

  localparam logic [1:0] LSU_ERR_OK       = 2'b00;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_ERR_BUS      = 2'b10;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b11;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LD  = 3'b011;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_LWU = 3'b110;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;
  localparam logic [2:0] INST_SD  = 3'b011;

  typedef struct packed {
    logic       store;
    logic [2:0] funct3;
  } lsu_op_t;

endpackage

// File: rtl/lsu_bus_ctrl_lane_align.sv
// Lane steering between the core and a full-width data bus: alignment check,
// byte strobes and store replication on the request side, load extract/extend on the response side.
module lsu_lane_align
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic [XLEN-1:0]           addr_i,
  input  logic                      store_i,
  input  logic [2:0]                funct3_i,
  input  logic [XLEN-1:0]           wdata_i,
  output logic                      misalign_o,
  output logic [XLEN-1:0]           addr_o,
  output logic [XLEN/8-1:0]         be_o,
  output logic [XLEN-1:0]           wdata_o,
  input  logic [$clog2(XLEN/8)-1:0] rsp_off_i,
  input  logic [2:0]                rsp_funct3_i,
  input  logic [XLEN-1:0]           rdata_i,
  output logic [XLEN-1:0]           rdata_o
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);

  logic [1:0]      size;
  logic [OW-1:0]   amask;
  logic [OW-1:0]   off;
  logic            unsupported;
  int              nbytes;
  logic [XLEN-1:0] rshift;

  // Keep the low `bits` of v, filling the rest with its top kept bit when sgn is set.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input int bits,
                                             input logic sgn);
    logic [XLEN-1:0] m;
    m = (bits >= int'(XLEN)) ? '1 : ((XLEN'(1) << bits) - XLEN'(1));
    return (v & m) | ((sgn && v[bits-1]) ? ~m : '0);
  endfunction

  always_comb begin : req_side
    size        = funct3_i[1:0];
    nbytes      = 1 << size;
    amask       = OW'(nbytes - 1);
    // Doubleword and LWU do not exist on a 32-bit core; odd store encodings are illegal.
    unsupported = (store_i && funct3_i[2])
                || ((XLEN == 32) && (size == 2'd3))
                || ((XLEN == 32) && !store_i && (funct3_i == INST_LWU));
    misalign_o  = unsupported || (MISALIGN_EN && ((addr_i[OW-1:0] & amask) != '0));
    off         = MISALIGN_EN ? addr_i[OW-1:0] : (addr_i[OW-1:0] & ~amask);
    addr_o      = {addr_i[XLEN-1:OW], off};
    for (int i = 0; i < int'(NB); i++) begin
      be_o[i]           = (i >= int'(off)) && (i < int'(off) + nbytes);
      wdata_o[8*i +: 8] = wdata_i[8*(i & (nbytes - 1)) +: 8];
    end
  end

  always_comb begin : rsp_side
    rshift = rdata_i >> {rsp_off_i, 3'b000};
    case (rsp_funct3_i)
      INST_LB:  rdata_o = extend(rshift, 8, 1'b1);
      INST_LH:  rdata_o = extend(rshift, 16, 1'b1);
      INST_LW:  rdata_o = extend(rshift, 32, 1'b1);
      INST_LBU: rdata_o = extend(rshift, 8, 1'b0);
      INST_LHU: rdata_o = extend(rshift, 16, 1'b0);
      INST_LWU: rdata_o = extend(rshift, 32, 1'b0);
      default:  rdata_o = rshift;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus master: one op per handshake, req/gnt/rvalid bus with strobes,
// pipeline hold while outstanding, misalign/bus-error/timeout fault reporting.
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic              flush_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic [1:0]        rsp_err_o,
  output logic              hold_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              mem_err_i
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [1:0]      state_q, state_d;
  lsu_op_t         op_q, op_d;
  logic [OW-1:0]   off_q, off_d;
  logic            drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [1:0]      err_q, err_d;
  logic            we_q, we_d;
  logic [NB-1:0]   be_q, be_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic [XLEN-1:0] mwdata_q, mwdata_d;
  logic            ready_q, hold_q, mreq_q, rspv_q;
  logic            to_hit;

  logic            al_misalign;
  logic [XLEN-1:0] al_addr;
  logic [NB-1:0]   al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;

  lsu_lane_align #(
    .XLEN        (XLEN),
    .MISALIGN_EN (MISALIGN_EN)
  ) u_align (
    .addr_i       (req_addr_i),
    .store_i      (req_store_i),
    .funct3_i     (req_funct3_i),
    .wdata_i      (req_wdata_i),
    .misalign_o   (al_misalign),
    .addr_o       (al_addr),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .rsp_off_i    (off_q),
    .rsp_funct3_i (op_q.funct3),
    .rdata_i      (mem_rdata_i),
    .rdata_o      (al_rdata)
  );

  // cnt_q counts completed REQ/WAIT cycles; it stops at the last allowed cycle.
  assign to_hit  = (TIMEOUT_CYC != 0) && (32'(cnt_q) == TIMEOUT_CYC - 1);
  assign cnt_inc = ((TIMEOUT_CYC == 0) || to_hit) ? cnt_q : cnt_q + CW'(1);

  always_comb begin : next_state
    state_d  = state_q;
    op_d     = op_q;
    off_d    = off_q;
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    we_d     = we_q;
    be_d     = be_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    case (state_q)
      LSU_ST_IDLE: begin
        if (req_valid_i) begin
          op_d.store  = req_store_i;
          op_d.funct3 = req_funct3_i;
          off_d       = al_addr[OW-1:0];
          drop_d      = 1'b0;
          cnt_d       = '0;
          rdata_d     = '0;
          if (al_misalign) begin
            err_d   = LSU_ERR_MISALIGN;
            state_d = LSU_ST_RESP;
          end else begin
            err_d    = LSU_ERR_OK;
            we_d     = req_store_i;
            be_d     = al_be;
            maddr_d  = {al_addr[XLEN-1:OW], {OW{1'b0}}};
            mwdata_d = al_wdata;
            state_d  = LSU_ST_REQ;
          end
        end
      end
      LSU_ST_REQ: begin
        cnt_d = cnt_inc;
        if (flush_i && !mem_gnt_i) begin
          state_d = LSU_ST_IDLE;
        end else if (to_hit) begin
          err_d   = LSU_ERR_TIMEOUT;
          state_d = LSU_ST_RESP;
        end else if (mem_gnt_i) begin
          // A flush racing the grant cannot cancel the bus op; swallow its response instead.
          drop_d  = flush_i;
          state_d = LSU_ST_WAIT;
        end
      end
      LSU_ST_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_rvalid_i) begin
          err_d   = mem_err_i ? LSU_ERR_BUS : LSU_ERR_OK;
          rdata_d = (mem_err_i || op_q.store) ? '0 : al_rdata;
          state_d = drop_q ? LSU_ST_IDLE : LSU_ST_RESP;
        end else if (to_hit) begin
          err_d   = LSU_ERR_TIMEOUT;
          state_d = drop_q ? LSU_ST_IDLE : LSU_ST_RESP;
        end
      end
      default: state_d = LSU_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LSU_ST_IDLE;
      op_q     <= '0;
      off_q    <= '0;
      drop_q   <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= LSU_ERR_OK;
      we_q     <= 1'b0;
      be_q     <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      ready_q  <= 1'b1;
      hold_q   <= 1'b0;
      mreq_q   <= 1'b0;
      rspv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      off_q    <= off_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      we_q     <= we_d;
      be_q     <= be_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      ready_q  <= (state_d == LSU_ST_IDLE);
      hold_q   <= (state_d == LSU_ST_REQ) || (state_d == LSU_ST_WAIT);
      mreq_q   <= (state_d == LSU_ST_REQ);
      rspv_q   <= (state_d == LSU_ST_RESP);
    end
  end

  assign req_ready_o = ready_q;
  assign hold_o      = hold_q;
  assign mem_req_o   = mreq_q;
  assign rsp_valid_o = rspv_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = maddr_q;
  assign mem_wdata_o = mwdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl (XLEN=32, TIMEOUT_CYC=8): directed cases plus
// randomized ops against an arithmetic model of strobes, extension, faults and timing.
module tb_lsu_bus_ctrl;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_store, flush, mem_gnt, mem_rvalid, mem_err;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic        req_ready_o, rsp_valid_o, hold_o, mem_req_o, mem_we_o;
  logic [31:0] rsp_rdata_o, mem_addr_o, mem_wdata_o;
  logic [1:0]  rsp_err_o;
  logic [3:0]  mem_be_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(
    .XLEN        (32),
    .TIMEOUT_CYC (TO),
    .MISALIGN_EN (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_store_i  (req_store),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .flush_i      (flush),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .hold_o       (hold_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .mem_err_i    (mem_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    flush      = 1'b0;
  endtask

  function automatic logic [1:0] m_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int unsigned nb;
    nb = 32'd1 << f3[1:0];
    if (f3[1:0] == 2'd3 || (!st && f3 == 3'd6) || (st && f3[2])) return 2'b01;
    if (a % nb != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned nb;
    nb = 32'd1 << f3[1:0];
    return 4'(((32'd1 << nb) - 32'd1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'd0:    return (w & 32'hFF) * 32'h0101_0101;
      2'd1:    return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    longint unsigned v, bits;
    v    = 64'(rd) >> (8 * (a % 4));
    bits = 8 * (64'd1 << f3[1:0]);
    v    = v % (64'd1 << bits);
    if (!f3[2] && v >= (64'd1 << (bits - 1))) v = v + (64'd1 << 32) - (64'd1 << bits);
    return 32'(v);
  endfunction

  // One op: gnt after gnt_dly REQ cycles, rvalid rv_dly cycles into WAIT,
  // optional flush at cycle flush_cyc (-1 = none), no_rv = the bus never answers.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rd, input logic berr, input int flush_cyc,
                        input logic no_rv);
    logic [1:0] e_err;
    int         rv_idx, end_idx, outcome;
    e_err = m_err(st, f3, addr);
    check_eq("ready_before", 32'(req_ready_o), 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    tick();
    req_valid = 1'b0;
    if (e_err == 2'b01) begin
      check_eq("mis_valid", 32'(rsp_valid_o), 32'd1);
      check_eq("mis_err", 32'(rsp_err_o), 32'd1);
      check_eq("mis_rdata", rsp_rdata_o, 32'd0);
      check_eq("mis_memreq", 32'(mem_req_o), 32'd0);
      check_eq("mis_hold", 32'(hold_o), 32'd0);
      tick();
      check_eq("mis_pulse", 32'(rsp_valid_o), 32'd0);
      check_eq("mis_ready", 32'(req_ready_o), 32'd1);
      return;
    end
    rv_idx  = gnt_dly + 1 + rv_dly;
    end_idx = int'(TO) - 1;
    outcome = 1;
    if (!no_rv && rv_idx <= end_idx) begin
      end_idx = rv_idx;
      outcome = 0;
    end
    if (flush_cyc >= 0 && flush_cyc < gnt_dly && flush_cyc <= end_idx) begin
      end_idx = flush_cyc;
      outcome = 2;
    end
    for (int k = 0; k <= end_idx; k++) begin
      check_eq("hold", 32'(hold_o), 32'd1);
      check_eq("mem_req", 32'(mem_req_o), 32'(k <= gnt_dly));
      check_eq("early_rsp", 32'(rsp_valid_o), 32'd0);
      if (k == 0) begin
        check_eq("be", 32'(mem_be_o), 32'(m_be(f3, addr)));
        check_eq("addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        check_eq("wdata", mem_wdata_o, m_wdata(f3, wd));
        check_eq("we", 32'(mem_we_o), 32'(st));
      end
      mem_gnt    = (k == gnt_dly);
      flush      = (k == flush_cyc);
      mem_rvalid = !no_rv && (k == rv_idx);
      mem_err    = berr && (k == rv_idx);
      mem_rdata  = (k == rv_idx) ? rd : $urandom;
      tick();
    end
    idle_bus();
    if (outcome == 2) begin
      check_eq("kill_rsp", 32'(rsp_valid_o), 32'd0);
      check_eq("kill_hold", 32'(hold_o), 32'd0);
      check_eq("kill_memreq", 32'(mem_req_o), 32'd0);
      check_eq("kill_ready", 32'(req_ready_o), 32'd1);
    end else begin
      check_eq("rsp_valid", 32'(rsp_valid_o), 32'd1);
      check_eq("rsp_hold", 32'(hold_o), 32'd0);
      check_eq("rsp_err", 32'(rsp_err_o),
               (outcome == 1) ? 32'd3 : (berr ? 32'd2 : 32'd0));
      check_eq("rsp_rdata", rsp_rdata_o,
               (outcome == 0 && !berr && !st) ? m_load(f3, addr, rd) : 32'd0);
      tick();
      check_eq("rsp_pulse", 32'(rsp_valid_o), 32'd0);
      check_eq("rsp_ready", 32'(req_ready_o), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic        st, berr, nr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rd;
    int          g, r, fl;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_rdata  = '0;
    idle_bus();
    tick();
    tick();
    check_eq("rst_ready", 32'(req_ready_o), 32'd1);
    check_eq("rst_hold", 32'(hold_o), 32'd0);
    check_eq("rst_memreq", 32'(mem_req_o), 32'd0);
    check_eq("rst_rspv", 32'(rsp_valid_o), 32'd0);
    check_eq("rst_be", 32'(mem_be_o), 32'd0);
    check_eq("rst_err", 32'(rsp_err_o), 32'd0);
    rst = 1'b0;
    tick();

    run_op(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0, -1, 1'b0);
    run_op(1'b1, 3'b000, 32'h103, 32'h0000_005A, 0, 0, 32'h0, 1'b0, -1, 1'b0);
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h8012_3456, 1'b0, -1, 1'b0);
    run_op(1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0, -1, 1'b0);
    run_op(1'b0, 3'b010, 32'h200, 32'h0, 4, 0, 32'h1234_5678, 1'b0, 2, 1'b0);
    run_op(1'b0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h0, 1'b0, -1, 1'b1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    idle_bus();
    check_eq("late_rv_rsp", 32'(rsp_valid_o), 32'd0);
    check_eq("late_rv_ready", 32'(req_ready_o), 32'd1);
    tick();
    check_eq("late_rv_rsp2", 32'(rsp_valid_o), 32'd0);
    run_op(1'b0, 3'b101, 32'h302, 32'h0, 1, 2, 32'hBEEF_0000, 1'b0, -1, 1'b0);
    run_op(1'b0, 3'b010, 32'h40, 32'h0, 3, 3, 32'h8765_4321, 1'b0, -1, 1'b0);
    run_op(1'b0, 3'b010, 32'h44, 32'h0, 9, 0, 32'h0, 1'b0, -1, 1'b0);
    run_op(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h8001_0000, 1'b1, -1, 1'b0);
    run_op(1'b0, 3'b011, 32'h108, 32'h0, 0, 0, 32'h0, 1'b0, -1, 1'b0);

    // reset while a load sits in WAIT
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h400;
    tick();
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check_eq("wait_hold", 32'(hold_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstw_ready", 32'(req_ready_o), 32'd1);
    check_eq("rstw_hold", 32'(hold_o), 32'd0);
    check_eq("rstw_rspv", 32'(rsp_valid_o), 32'd0);
    mem_rvalid = 1'b1;
    tick();
    idle_bus();
    check_eq("rstw_rspv2", 32'(rsp_valid_o), 32'd0);
    // reset while a request is pending on the bus
    req_valid = 1'b1;
    req_addr  = 32'h404;
    tick();
    req_valid = 1'b0;
    check_eq("rstr_memreq_pre", 32'(mem_req_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstr_memreq", 32'(mem_req_o), 32'd0);
    check_eq("rstr_rspv", 32'(rsp_valid_o), 32'd0);

    for (int n = 0; n < 60; n++) begin
      st   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      if (st) f3[2] = 1'b0;
      addr = 32'h1000 + 32'($urandom_range(0, 63));
      wd   = $urandom;
      rd   = $urandom;
      g    = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
      r    = int'($urandom_range(0, 3));
      berr = ($urandom_range(0, 7) == 0);
      nr   = ($urandom_range(0, 9) == 0);
      fl   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 5)) : -1;
      if (fl == g) fl = -1;
      run_op(st, f3, addr, wd, g, r, rd, berr, fl, nr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
